// File: rtl/data_cache_ctrl_if.sv
// Bus bundle for the data cache: CPU-side load/store port, memory request/valid port, counters.
// The cache connects through the slave modport; the pipeline/memory environment uses master.
interface data_cache_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              cpu_read;
  logic              cpu_write;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [1:0]        cpu_size;
  logic [31:0]       cpu_rdata;
  logic              cpu_stall;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [1:0]        mem_size;
  logic [31:0]       mem_rdata;
  logic              mem_valid;
  logic [31:0]       hit_count;
  logic [31:0]       miss_count;

  modport slave (
    input  cpu_read, cpu_write, cpu_addr, cpu_wdata, cpu_size, mem_rdata, mem_valid,
    output cpu_rdata, cpu_stall, mem_read, mem_write, mem_addr, mem_wdata, mem_size,
           hit_count, miss_count
  );

  modport master (
    output cpu_read, cpu_write, cpu_addr, cpu_wdata, cpu_size, mem_rdata, mem_valid,
    input  cpu_rdata, cpu_stall, mem_read, mem_write, mem_addr, mem_wdata, mem_size,
           hit_count, miss_count
  );
endinterface

// File: rtl/data_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines.
// Read hits complete combinationally; misses fill one word, stores always go to memory.
module data_cache_ctrl #(
  parameter int SETS   = 64,
  parameter int ADDR_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  data_cache_ctrl_if.slave bus
);
  localparam int IDX   = $clog2(SETS);
  localparam int TAG_W = ADDR_W - 2 - IDX;

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_e;
  state_e state_q, state_d;

  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [31:0]       data_q [SETS];
  logic [SETS-1:0]   valid_q;

  logic              mem_read_q, mem_write_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic [1:0]        mem_size_q;
  logic [31:0]       hit_cnt_q, miss_cnt_q;

  logic [IDX-1:0]    idx;
  logic [TAG_W-1:0]  tag;
  logic              hit;
  logic              cpu_stall;
  logic [31:0]       cpu_rdata;

  function automatic logic [31:0] merge_store(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [1:0] size, input logic [1:0] off);
    logic [31:0] r;
    r = old;
    case (size)
      2'b00: r = wd;
      2'b01: if (off[1]) r[31:16] = wd[15:0]; else r[15:0] = wd[15:0];
      2'b10: r[{off, 3'b000} +: 8] = wd[7:0];
      default: r = old;
    endcase
    return r;
  endfunction

  // Lookup uses the live CPU address in IDLE and the captured request while one is in flight
  assign idx = (state_q == IDLE) ? bus.cpu_addr[2 +: IDX] : mem_addr_q[2 +: IDX];
  assign tag = (state_q == IDLE) ? bus.cpu_addr[ADDR_W-1 -: TAG_W] : mem_addr_q[ADDR_W-1 -: TAG_W];
  assign hit = valid_q[idx] && (tag_q[idx] == tag);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.cpu_write)              state_d = WRITE;
        else if (bus.cpu_read && !hit)  state_d = FILL;
      end
      FILL:    if (bus.mem_valid) state_d = IDLE;
      WRITE:   if (bus.mem_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cpu_stall = 1'b0;
    cpu_rdata = 32'd0;
    case (state_q)
      IDLE: begin
        if (bus.cpu_write) begin
          cpu_stall = 1'b1;
        end else if (bus.cpu_read) begin
          cpu_stall = !hit;
          if (hit) cpu_rdata = data_q[idx];
        end
      end
      FILL: begin
        cpu_stall = !bus.mem_valid;
        if (bus.mem_valid) cpu_rdata = bus.mem_rdata;
      end
      WRITE:   cpu_stall = !bus.mem_valid;
      default: cpu_stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      mem_size_q  <= 2'b00;
      hit_cnt_q   <= 32'd0;
      miss_cnt_q  <= 32'd0;
      valid_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cpu_write) begin
            mem_addr_q  <= bus.cpu_addr;
            mem_wdata_q <= bus.cpu_wdata;
            mem_size_q  <= bus.cpu_size;
            mem_write_q <= 1'b1;
          end else if (bus.cpu_read) begin
            if (hit) begin
              hit_cnt_q <= hit_cnt_q + 32'd1;
            end else begin
              mem_addr_q <= {bus.cpu_addr[ADDR_W-1:2], 2'b00};
              mem_size_q <= 2'b00;
              mem_read_q <= 1'b1;
              miss_cnt_q <= miss_cnt_q + 32'd1;
            end
          end
        end
        FILL: begin
          if (bus.mem_valid) begin
            mem_read_q   <= 1'b0;
            valid_q[idx] <= 1'b1;
          end
        end
        WRITE:   if (bus.mem_valid) mem_write_q <= 1'b0;
        default: ;
      endcase
    end
  end

  // Tag/data storage is never reset; only valid bits qualify its contents
  always_ff @(posedge clk) begin
    if (rst_n && bus.mem_valid) begin
      if (state_q == FILL) begin
        data_q[idx] <= bus.mem_rdata;
        tag_q[idx]  <= tag;
      end else if (state_q == WRITE && hit) begin
        data_q[idx] <= merge_store(data_q[idx], mem_wdata_q, mem_size_q, mem_addr_q[1:0]);
      end
    end
  end

  assign bus.cpu_stall  = cpu_stall;
  assign bus.cpu_rdata  = cpu_rdata;
  assign bus.mem_read   = mem_read_q;
  assign bus.mem_write  = mem_write_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_size   = mem_size_q;
  assign bus.hit_count  = hit_cnt_q;
  assign bus.miss_count = miss_cnt_q;
endmodule

// File: tb/tb_data_cache_ctrl.sv
// Bench for data_cache_ctrl: acts as CPU pipeline and memory, keeps a line-level cache model
// and compares every DUT output each cycle, plus directed scenarios with literal expectations.
module tb_data_cache_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_cache_ctrl_if #(.ADDR_W(32)) bus ();

  data_cache_ctrl #(.SETS(64), .ADDR_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Model: per-set valid/tag/data, read counters
  bit          mv [64];
  logic [23:0] mt [64];
  logic [31:0] md [64];
  int unsigned m_hits, m_miss;

  // Expectations for the current cycle
  logic        e_stall, e_mr, e_mw, chk_mem, chk_en, pin_en;
  logic [31:0] e_rdata, e_addr, e_wdata, pin_val;
  logic [1:0]  e_size;

  // Model action taking effect at the next clock edge: 0 none, 1 hit, 2 miss, 3 fill, 4 store, 5 reset
  int          pk;
  logic [31:0] p_addr, p_data;
  logic [1:0]  p_size;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    if (chk_en) begin
      chk("cpu_stall", {31'd0, bus.cpu_stall}, {31'd0, e_stall});
      chk("cpu_rdata", bus.cpu_rdata, e_rdata);
      chk("mem_read", {31'd0, bus.mem_read}, {31'd0, e_mr});
      chk("mem_write", {31'd0, bus.mem_write}, {31'd0, e_mw});
      chk("hit_count", bus.hit_count, m_hits);
      chk("miss_count", bus.miss_count, m_miss);
      if (chk_mem) begin
        chk("mem_addr", bus.mem_addr, e_addr);
        chk("mem_size", {30'd0, bus.mem_size}, {30'd0, e_size});
        if (e_mw) chk("mem_wdata", bus.mem_wdata, e_wdata);
      end
      if (pin_en) chk("pinned_rdata", bus.cpu_rdata, pin_val);
    end
  endtask

  task automatic apply_pending();
    int i;
    i = int'(p_addr[7:2]);
    case (pk)
      1: m_hits++;
      2: m_miss++;
      3: begin mv[i] = 1'b1; mt[i] = p_addr[31:8]; md[i] = p_data; end
      4: if (mv[i] && mt[i] == p_addr[31:8]) begin
        for (int b = 0; b < 4; b++) begin
          bit sel;
          logic [7:0] src;
          sel = (p_size == 2'b00) || (p_size == 2'b01 && (b / 2) == int'(p_addr[1])) ||
                (p_size == 2'b10 && b == int'(p_addr[1:0]));
          src = (p_size == 2'b00) ? p_data[8*b +: 8] :
                (p_size == 2'b01) ? p_data[8*(b%2) +: 8] : p_data[7:0];
          if (sel) md[i][8*b +: 8] = src;
        end
      end
      5: begin
        for (int s = 0; s < 64; s++) mv[s] = 1'b0;
        m_hits = 0;
        m_miss = 0;
      end
      default: ;
    endcase
    pk = 0;
  endtask

  task automatic tick();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    apply_pending();
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      bus.cpu_read = 1'b0; bus.cpu_write = 1'b0;
      bus.mem_valid = 1'($urandom % 2); bus.mem_rdata = $urandom;
      e_stall = 1'b0; e_rdata = 32'd0; e_mr = 1'b0; e_mw = 1'b0; chk_mem = 1'b0;
      tick();
    end
  endtask

  task automatic rd(input logic [31:0] a, input int nw, input logic [31:0] fill, input bit pin,
                    input logic [31:0] pv);
    bit h;
    int i;
    i = int'(a[7:2]);
    h = mv[i] && mt[i] == a[31:8];
    bus.cpu_read = 1'b1; bus.cpu_write = 1'b0; bus.cpu_addr = a; bus.cpu_size = 2'b00;
    bus.cpu_wdata = $urandom; bus.mem_valid = 1'($urandom % 2); bus.mem_rdata = $urandom;
    e_stall = !h; e_rdata = h ? md[i] : 32'd0; e_mr = 1'b0; e_mw = 1'b0; chk_mem = 1'b0;
    pin_en = pin && h; pin_val = pv;
    pk = h ? 1 : 2;
    tick();
    pin_en = 1'b0;
    if (!h) begin
      e_mr = 1'b1; chk_mem = 1'b1; e_addr = {a[31:2], 2'b00}; e_size = 2'b00;
      repeat (nw) begin
        bus.mem_valid = 1'b0; bus.mem_rdata = $urandom;
        e_stall = 1'b1; e_rdata = 32'd0;
        tick();
      end
      bus.mem_valid = 1'b1; bus.mem_rdata = fill;
      e_stall = 1'b0; e_rdata = fill;
      pin_en = pin; pin_val = pv;
      pk = 3; p_addr = a; p_data = fill;
      tick();
      pin_en = 1'b0;
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz,
                    input int nw, input bit both);
    bus.cpu_read = both; bus.cpu_write = 1'b1; bus.cpu_addr = a; bus.cpu_wdata = wd;
    bus.cpu_size = sz; bus.mem_valid = 1'($urandom % 2); bus.mem_rdata = $urandom;
    e_stall = 1'b1; e_rdata = 32'd0; e_mr = 1'b0; e_mw = 1'b0; chk_mem = 1'b0;
    tick();
    e_mw = 1'b1; chk_mem = 1'b1; e_addr = a; e_size = sz; e_wdata = wd;
    repeat (nw) begin
      bus.mem_valid = 1'b0; bus.mem_rdata = $urandom;
      e_stall = 1'b1;
      tick();
    end
    bus.mem_valid = 1'b1; bus.mem_rdata = $urandom;
    e_stall = 1'b0;
    pk = 4; p_addr = a; p_data = wd; p_size = sz;
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    chk_en = 1'b0;
    pk = 5;
    tick();
    rst_n = 1'b1;
    chk_en = 1'b1;
    bus.cpu_read = 1'b0; bus.cpu_write = 1'b0; bus.mem_valid = 1'b0;
    e_stall = 1'b0; e_rdata = 32'd0; e_mr = 1'b0; e_mw = 1'b0;
    chk_mem = 1'b1; e_addr = 32'd0; e_size = 2'b00;
    @(negedge clk);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    @(posedge clk); #1;
    chk_mem = 1'b0;
    idle(1);
  endtask

  initial begin
    pk = 0; pin_en = 1'b0; chk_en = 1'b0; chk_mem = 1'b0; pin_val = 32'd0;
    p_addr = 32'd0; p_data = 32'd0; p_size = 2'b00;
    m_hits = 0; m_miss = 0;
    e_addr = 32'd0; e_wdata = 32'd0; e_size = 2'b00;
    bus.cpu_read = 1'b0; bus.cpu_write = 1'b0; bus.cpu_addr = 32'd0; bus.cpu_wdata = 32'd0;
    bus.cpu_size = 2'b00; bus.mem_rdata = 32'd0; bus.mem_valid = 1'b0;
    #1;
    do_reset();

    // T1: miss with fill two cycles after the request, then hit
    rd(32'h100, 1, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF);
    rd(32'h100, 0, 32'h0, 1'b1, 32'hDEADBEEF);
    chk("t1_hits", bus.hit_count, 32'd1);
    chk("t1_miss", bus.miss_count, 32'd1);

    // T2: conflicting tags on set 0
    rd(32'h100, 0, 32'h0, 1'b0, 32'h0);
    rd(32'h200, 2, 32'h0BADF00D, 1'b0, 32'h0);
    rd(32'h100, 1, 32'hDEADBEEF, 1'b0, 32'h0);
    chk("t2_miss", bus.miss_count, 32'd3);

    // T3: byte store into a resident line
    wr(32'h101, 32'h000000AA, 2'b10, 1, 1'b0);
    rd(32'h100, 0, 32'h0, 1'b1, 32'hDEADAAEF);

    // T4: store miss does not allocate
    wr(32'h300, 32'h12345678, 2'b00, 0, 1'b0);
    rd(32'h300, 1, 32'h12345678, 1'b0, 32'h0);
    chk("t4_hits", bus.hit_count, 32'd3);
    chk("t4_miss", bus.miss_count, 32'd4);

    // T5: reset while a fill is outstanding
    bus.cpu_read = 1'b1; bus.cpu_write = 1'b0; bus.cpu_addr = 32'h400; bus.mem_valid = 1'b0;
    e_stall = 1'b1; e_rdata = 32'd0; e_mr = 1'b0; e_mw = 1'b0; chk_mem = 1'b0;
    pk = 2;
    tick();
    e_mr = 1'b1;
    tick();
    do_reset();
    chk("t5_hits", bus.hit_count, 32'd0);
    chk("t5_miss", bus.miss_count, 32'd0);
    rd(32'h300, 0, 32'h55AA55AA, 1'b0, 32'h0);
    chk("t5_miss_after", bus.miss_count, 32'd1);

    // T6: simultaneous read and write takes the write path only
    wr(32'h104, 32'hCAFEF00D, 2'b00, 1, 1'b1);
    chk("t6_hits", bus.hit_count, 32'd0);
    chk("t6_miss", bus.miss_count, 32'd1);

    // Random mix over a few sets and tags to exercise hits, conflicts and merges
    for (int n = 0; n < 400; n++) begin
      int op;
      logic [31:0] a;
      logic [1:0]  sz;
      op = int'($urandom % 10);
      a = {22'd0, 2'($urandom % 4), 6'($urandom % 4), 2'b00};
      if (op < 5) begin
        rd(a, int'($urandom % 4), $urandom, 1'b0, 32'h0);
      end else if (op < 9) begin
        sz = 2'($urandom % 3);
        if (sz == 2'b01) a[1] = 1'($urandom % 2);
        if (sz == 2'b10) a[1:0] = 2'($urandom % 4);
        wr(a, $urandom, sz, int'($urandom % 4), 1'($urandom % 2));
      end else begin
        idle(1 + int'($urandom % 3));
      end
    end
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
